// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_converter
// Description : Sequential packed-BCD to binary converter. Accepts one
//               operand of NDIGITS BCD digits through a valid/ready
//               handshake. It converts the operand one digit per clock,
//               most significant digit first (acc = acc*10 + digit). The
//               result is presented through a second valid/ready handshake.
//               A nibble greater than 9 flags an error. The digit index of
//               the most significant bad nibble is reported, and the binary
//               result is forced to 0.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               in_valid   - operand offered
//               in_ready   - operand can be accepted (IDLE only)
//               bcd_in     - packed BCD operand, digit NDIGITS-1 is the MSD
//               out_valid  - result available (DONE only)
//               out_ready  - consumer takes the result
//               binary     - converted value (0 when error)
//               error      - operand held a non-BCD nibble
//               err_pos    - index of the most significant bad nibble
//               busy       - conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_converter #(
  parameter  int NDIGITS = 4,
  parameter  int BIN_W   = 14,
  localparam int POS_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] bcd_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     binary,
  output logic                 error,
  output logic [POS_W-1:0]     err_pos,
  output logic                 busy
);

  localparam logic [BIN_W-1:0] C_TEN      = BIN_W'(10);
  localparam logic [POS_W-1:0] C_CNT_INIT = POS_W'(NDIGITS - 1);
  localparam logic [POS_W-1:0] C_CNT_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q,   state_d;
  logic [4*NDIGITS-1:0]   operand_q, operand_d;
  logic [BIN_W-1:0]       acc_q,     acc_d;
  logic [POS_W-1:0]       cnt_q,     cnt_d;
  logic                   err_q,     err_d;
  logic [POS_W-1:0]       err_pos_q, err_pos_d;

  logic [4*NDIGITS-1:0]   digit_sh;
  logic [3:0]             digit;
  logic [BIN_W-1:0]       digit_ext;

  // The current digit is selected by shifting the operand right by 4*cnt.
  always_comb begin
    digit_sh  = operand_q >> {cnt_q, 2'b00};
    digit     = digit_sh[3:0];
    digit_ext = {{(BIN_W-4){1'b0}}, digit};
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_pos_d = err_pos_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          operand_d = bcd_in;
          acc_d     = '0;
          err_d     = 1'b0;
          err_pos_d = '0;
          cnt_d     = C_CNT_INIT;
          state_d   = S_CONV;
        end
      end

      S_CONV: begin
        // Bad digits still go through the accumulator. This keeps the
        // latency fixed, and the result is masked at the output anyway.
        acc_d = acc_q * C_TEN + digit_ext;
        // Only the first bad digit is recorded. Scanning runs MSD first,
        // so that digit is the most significant one.
        if ((digit > 4'd9) && !err_q) begin
          err_d     = 1'b1;
          err_pos_d = cnt_q;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_pos_q <= err_pos_d;
    end
  end

  // Result outputs are driven only in DONE and are 0 elsewhere. Nothing
  // changes state while waiting in DONE, so they stay stable under
  // backpressure.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_CONV);
    binary    = (out_valid && !err_q) ? acc_q : '0;
    error     = out_valid && err_q;
    err_pos   = (out_valid && err_q) ? err_pos_q : '0;
  end

endmodule
`default_nettype wire
